vga_timing_generator: RTL
=========================

Name: vga_timing_generator

Overview:
- Produces the VGA raster: pixel/line counters, HS/VS sync and active-video window for 640x480@60.
- Drives pixelX/pixelY to every drawing object and to the object mux; receives the final 8-bit RRRGGGBB pixel back from the mux.
- Aligns that pixel, the sync signals and the blanking with a fixed pipeline delay, then expands it to 4-4-4 DAC outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..8
- PIPE_DELAY, 2, clk cycles from a pixelX/pixelY value to its RGBin being valid; legal range 1..4
- SYNC_POL, 0, asserted level of vgaHS/vgaVS

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- RGBin  in  8  final pixel from the object mux, RRRGGGBB
- pixelX  out  11 signed  current horizontal count
- pixelY  out  11 signed  current vertical count
- pixelEnable  out  1  one-clk strobe on the last clk of each pixel
- startOfFrame  out  1  one-clk pulse at each frame start
- frameCount  out  16  frames completed, wraps
- vgaR / vgaG / vgaB  out  4 each  DAC colour
- vgaHS / vgaVS  out  1  sync
- vgaBlankN  out  1  high inside active video

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async, any time, including mid-line): divCnt=0, hCnt=0, vCnt=0, frameCount=0, pipeline cleared to inactive.
  - Outputs during reset: pixelEnable=0, startOfFrame=0, vgaR/G/B=0, vgaBlankN=0, vgaHS=vgaVS=~SYNC_POL.
  - After release, the first pixel (0,0) is held for a full PIX_DIV clks. No startOfFrame pulse is emitted for this first frame.
- Pixel divider: divCnt counts 0..PIX_DIV-1 every clk and wraps. pixelEnable = (divCnt==PIX_DIV-1), combinational from registered divCnt. With PIX_DIV=1, pixelEnable is always 1.
- Counters advance only on pixelEnable:
  - hCnt wraps H_TOTAL-1 -> 0.
  - vCnt increments when hCnt wraps, and wraps V_TOTAL-1 -> 0.
  - pixelX=hCnt and pixelY=vCnt, zero-extended, always non-negative.
  - Counters run through the blanking intervals; pixelX reaches 799 and pixelY reaches 524.
- Frame start: on the edge where (hCnt,vCnt) wraps to (0,0), the registered startOfFrame is 1 for exactly one clk and frameCount increments, wrapping 0xFFFF -> 0.
- Raw timing, combinational from the counters:
  - hs_raw = hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - act_raw = hCnt<H_ACTIVE && vCnt<V_ACTIVE
- Alignment: {hs_raw, vs_raw, act_raw} pass through a PIPE_DELAY-deep clk-rate shift register.
  - The output registers sample the tap and RGBin in the same clk.
  - Counter state at cycle t therefore appears on vgaHS/VS/BlankN/RGB at cycle t+PIPE_DELAY+1.
  - vgaHS = tap_hs ? SYNC_POL : ~SYNC_POL; vgaVS likewise.
- Colour, when the delayed act=1:
  - vgaR = {RGBin[7:5], RGBin[7]}
  - vgaG = {RGBin[4:2], RGBin[4]}
  - vgaB = {RGBin[1:0], RGBin[1:0]}
  - When act=0, vgaR/G/B=0 regardless of RGBin.
  - 8'hFF is displayed as white; transparency is resolved upstream.
- Simultaneous events: an H wrap and a V wrap on the same strobe behave as one frame start. Reset overrides everything.

Test Plan:
- Reset: hold reset 5 clks while driving RGBin=8'hFF -> all outputs at reset values, vgaHS=vgaVS=1, RGB=0. After release, pixelX steps to 1 on clk 2 and pixelEnable toggles 0,1.
- Line timing (defaults): measure vgaHS -> low for 192 clks, line period 1600 clks. The falling edge arrives PIPE_DELAY+1 clks after pixelX becomes 656.
- Frame timing: vgaVS is low for 2 lines (3200 clks); startOfFrame period is 840000 clks; frameCount 0->1->2 over two frames. Force frameCount to 0xFFFF and check the wrap to 0.
- Alignment: model an upstream stage with RGBin = pixelX[7:0] delayed 2 clks. Check output = expansion of the value for the pixel being shown, and 0 outside active (pixelX 640..799, lines 480..524).
- Colour expansion: RGBin 8'hE0 -> F,0,0; 8'h1C -> 0,F,0; 8'h92 -> 9,9,A; 8'h03 -> 0,0,F.
- Reset mid-line: assert reset at hCnt=300, vCnt=100 for 3 clks -> outputs go to reset values immediately (no clk edge needed). After release, counting restarts at (0,0) and the next startOfFrame comes a full 840000 clks later.

Source files
------------

// File: rtl/vga_timing_generator_if.sv
// Pixel-side bundle of the VGA timing generator: raster position and strobes out,
// mixed pixel back in, DAC colour and sync out.
interface vga_timing_generator_if;
    logic [7:0]         RGBin;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               pixelEnable;
    logic               startOfFrame;
    logic [15:0]        frameCount;
    logic [3:0]         vgaR;
    logic [3:0]         vgaG;
    logic [3:0]         vgaB;
    logic               vgaHS;
    logic               vgaVS;
    logic               vgaBlankN;

    modport master (
        input  RGBin,
        output pixelX, pixelY, pixelEnable, startOfFrame, frameCount,
        output vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN
    );

    modport slave (
        output RGBin,
        input  pixelX, pixelY, pixelEnable, startOfFrame, frameCount,
        input  vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN
    );
endinterface

// File: rtl/vga_timing_generator.sv
// VGA raster generator: pixel divider, H/V counters, frame strobe, and a sync/blank
// delay line that lines up with the externally mixed pixel before 4-4-4 expansion.
module vga_timing_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIX_DIV    = 2,
    parameter int PIPE_DELAY = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    vga_timing_generator_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0]  DIV_LAST = 3'(PIX_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } timing_t;

    logic [2:0]  r_div_cnt;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_sof;
    logic [15:0] r_frame_count;
    timing_t     r_pipe [PIPE_DELAY];
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic [3:0]  r_red;
    logic [3:0]  r_green;
    logic [3:0]  r_blue;

    logic        w_div_last;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_wrap;
    timing_t     w_raw;
    timing_t     w_tap;

    assign w_div_last   = (r_div_cnt == DIV_LAST);
    assign w_h_last     = (r_h_cnt == H_LAST);
    assign w_v_last     = (r_v_cnt == V_LAST);
    assign w_frame_wrap = w_div_last && w_h_last && w_v_last;
    assign w_tap        = r_pipe[PIPE_DELAY-1];

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would make results depend on statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_sof         <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_div_cnt <= w_div_last ? 3'd0 : r_div_cnt + 3'd1;
            r_sof     <= w_frame_wrap;
            if (w_div_last) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 11'd1;
                end
            end
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every variable of a combinational block gets a default first, so no path leaves it holding state (a latch).
        w_raw     = '0;
        w_raw.hs  = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
        w_raw.vs  = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
        w_raw.act = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    end

    // Shallow delay line covering the latency of the drawing objects and the mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this small array is a register chain, not RAM, so resetting each stage is cheap and keeps the output inactive.
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else begin
            r_hs      <= w_tap.hs ? SYNC_POL : ~SYNC_POL;
            r_vs      <= w_tap.vs ? SYNC_POL : ~SYNC_POL;
            r_blank_n <= w_tap.act;
            r_red     <= w_tap.act ? {bus.RGBin[7:5], bus.RGBin[7]}   : 4'h0;
            r_green   <= w_tap.act ? {bus.RGBin[4:2], bus.RGBin[4]}   : 4'h0;
            r_blue    <= w_tap.act ? {bus.RGBin[1:0], bus.RGBin[1:0]} : 4'h0;
        end
    end

    // Strobe is forced low while reset is held, even when PIX_DIV is 1.
    assign bus.pixelEnable  = w_div_last & ~reset;
    assign bus.pixelX       = $signed(r_h_cnt);
    assign bus.pixelY       = $signed(r_v_cnt);
    assign bus.startOfFrame = r_sof;
    assign bus.frameCount   = r_frame_count;
    assign bus.vgaHS        = r_hs;
    assign bus.vgaVS        = r_vs;
    assign bus.vgaBlankN    = r_blank_n;
    assign bus.vgaR         = r_red;
    assign bus.vgaG         = r_green;
    assign bus.vgaB         = r_blue;
endmodule
